// File: rtl/instruction_decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : instruction_decode_stage
// Brief   : LEGv8 decode stage (register file, immediates, load-use hazard
//           detection and the ID/EX pipeline register).
// Revision: 1.0 - initial release
// ============================================================================
module instruction_decode_stage #(
    parameter int         DATA_WIDTH = 64,
    parameter logic [4:0] ZERO_REG   = 5'd31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instructionStageIn,
    input  logic [DATA_WIDTH-1:0] pcStageIn,
    input  logic                  flush,
    input  logic                  wbRegWrite,
    input  logic [4:0]            wbRd,
    input  logic [DATA_WIDTH-1:0] wbData,
    output logic                  stall,
    output logic                  exValid,
    output logic [DATA_WIDTH-1:0] exPC,
    output logic [DATA_WIDTH-1:0] exReadData1,
    output logic [DATA_WIDTH-1:0] exReadData2,
    output logic [DATA_WIDTH-1:0] exImm,
    output logic [4:0]            exRd,
    output logic [4:0]            exRn,
    output logic [4:0]            exRm2,
    output logic                  exRegWrite,
    output logic                  exMemRead,
    output logic                  exMemWrite,
    output logic                  exALUSrc,
    output logic                  exSetFlags,
    output logic                  exBranch,
    output logic                  exCBZ,
    output logic                  exBLT,
    output logic [2:0]            exALUOp
);

    localparam logic [2:0] c_ALU_PASS = 3'b000;
    localparam logic [2:0] c_ALU_ADD  = 3'b010;
    localparam logic [2:0] c_ALU_SUB  = 3'b011;
    localparam logic [2:0] c_ALU_AND  = 3'b100;

    logic [DATA_WIDTH-1:0] r_regs [0:31];

    logic [31:0]           w_instr;
    logic [4:0]            w_rn;
    logic [4:0]            w_rd;
    logic [4:0]            w_rm2;
    logic                  w_usesRm2;
    logic                  w_valid;
    logic                  w_regWrite, w_memRead, w_memWrite, w_aluSrc;
    logic                  w_setFlags, w_branch, w_cbz, w_blt;
    logic [2:0]            w_aluOp;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [DATA_WIDTH-1:0] w_readData1;
    logic [DATA_WIDTH-1:0] w_readData2;
    logic                  w_hazard;

    logic                  r_exValid;
    logic [DATA_WIDTH-1:0] r_exPC, r_exReadData1, r_exReadData2, r_exImm;
    logic [4:0]            r_exRd, r_exRn, r_exRm2;
    logic                  r_exRegWrite, r_exMemRead, r_exMemWrite, r_exALUSrc;
    logic                  r_exSetFlags, r_exBranch, r_exCBZ, r_exBLT;
    logic [2:0]            r_exALUOp;

    assign w_instr = instructionStageIn;
    assign w_rn    = w_instr[9:5];
    assign w_rd    = w_instr[4:0];

    always_comb begin
        w_valid    = 1'b1;
        w_regWrite = 1'b0;
        w_memRead  = 1'b0;
        w_memWrite = 1'b0;
        w_aluSrc   = 1'b0;
        w_setFlags = 1'b0;
        w_branch   = 1'b0;
        w_cbz      = 1'b0;
        w_blt      = 1'b0;
        w_aluOp    = c_ALU_PASS;
        w_imm      = '0;
        w_rm2      = ZERO_REG;
        w_usesRm2  = 1'b0;
        if (w_instr[31:22] == 10'b1001000100) begin
            w_regWrite = 1'b1;
            w_aluSrc   = 1'b1;
            w_aluOp    = c_ALU_ADD;
            w_imm      = {{(DATA_WIDTH-12){1'b0}}, w_instr[21:10]};
        end else if (w_instr[31:21] == 11'b10101011000) begin
            w_regWrite = 1'b1;
            w_setFlags = 1'b1;
            w_aluOp    = c_ALU_ADD;
            w_rm2      = w_instr[20:16];
            w_usesRm2  = 1'b1;
        end else if (w_instr[31:21] == 11'b11101011000) begin
            w_regWrite = 1'b1;
            w_setFlags = 1'b1;
            w_aluOp    = c_ALU_SUB;
            w_rm2      = w_instr[20:16];
            w_usesRm2  = 1'b1;
        end else if (w_instr[31:21] == 11'b10001010000) begin
            w_regWrite = 1'b1;
            w_aluOp    = c_ALU_AND;
            w_rm2      = w_instr[20:16];
            w_usesRm2  = 1'b1;
        end else if (w_instr[31:21] == 11'b11111000010) begin
            w_regWrite = 1'b1;
            w_memRead  = 1'b1;
            w_aluSrc   = 1'b1;
            w_aluOp    = c_ALU_ADD;
            w_imm      = {{(DATA_WIDTH-9){w_instr[20]}}, w_instr[20:12]};
        end else if (w_instr[31:21] == 11'b11111000000) begin
            w_memWrite = 1'b1;
            w_aluSrc   = 1'b1;
            w_aluOp    = c_ALU_ADD;
            w_imm      = {{(DATA_WIDTH-9){w_instr[20]}}, w_instr[20:12]};
            w_rm2      = w_instr[4:0];
            w_usesRm2  = 1'b1;
        end else if (w_instr[31:26] == 6'b000101) begin
            w_branch   = 1'b1;
            w_imm      = {{(DATA_WIDTH-28){w_instr[25]}}, w_instr[25:0], 2'b00};
        end else if (w_instr[31:24] == 8'b10110100) begin
            w_cbz      = 1'b1;
            w_aluOp    = c_ALU_PASS;
            w_imm      = {{(DATA_WIDTH-21){w_instr[23]}}, w_instr[23:5], 2'b00};
            w_rm2      = w_instr[4:0];
            w_usesRm2  = 1'b1;
        end else if (w_instr[31:24] == 8'b01010100 && w_instr[4:0] == 5'b01011) begin
            w_blt      = 1'b1;
            w_imm      = {{(DATA_WIDTH-21){w_instr[23]}}, w_instr[23:5], 2'b00};
        end else begin
            w_valid    = 1'b0;
        end
    end

    // XZR always reads zero; a same-cycle write-back is bypassed onto the read.
    assign w_readData1 = (w_rn == ZERO_REG) ? '0 :
                         (wbRegWrite && wbRd == w_rn) ? wbData : r_regs[w_rn];
    assign w_readData2 = (w_rm2 == ZERO_REG) ? '0 :
                         (wbRegWrite && wbRd == w_rm2) ? wbData : r_regs[w_rm2];

    assign w_hazard = reset && !flush && r_exMemRead && r_exValid &&
                      (r_exRd != ZERO_REG) &&
                      ((r_exRd == w_rn) || (w_usesRm2 && r_exRd == w_rm2));
    assign stall    = w_hazard;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wbRegWrite && wbRd != ZERO_REG) begin
            r_regs[wbRd] <= wbData;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_exValid     <= 1'b0;
            r_exPC        <= '0;
            r_exReadData1 <= '0;
            r_exReadData2 <= '0;
            r_exImm       <= '0;
            r_exRd        <= '0;
            r_exRn        <= '0;
            r_exRm2       <= '0;
            r_exRegWrite  <= 1'b0;
            r_exMemRead   <= 1'b0;
            r_exMemWrite  <= 1'b0;
            r_exALUSrc    <= 1'b0;
            r_exSetFlags  <= 1'b0;
            r_exBranch    <= 1'b0;
            r_exCBZ       <= 1'b0;
            r_exBLT       <= 1'b0;
            r_exALUOp     <= c_ALU_PASS;
        end else if (flush || w_hazard || !w_valid) begin
            r_exValid     <= 1'b0;
            r_exPC        <= '0;
            r_exReadData1 <= '0;
            r_exReadData2 <= '0;
            r_exImm       <= '0;
            r_exRd        <= ZERO_REG;
            r_exRn        <= '0;
            r_exRm2       <= '0;
            r_exRegWrite  <= 1'b0;
            r_exMemRead   <= 1'b0;
            r_exMemWrite  <= 1'b0;
            r_exALUSrc    <= 1'b0;
            r_exSetFlags  <= 1'b0;
            r_exBranch    <= 1'b0;
            r_exCBZ       <= 1'b0;
            r_exBLT       <= 1'b0;
            r_exALUOp     <= c_ALU_PASS;
        end else begin
            r_exValid     <= 1'b1;
            r_exPC        <= pcStageIn;
            r_exReadData1 <= w_readData1;
            r_exReadData2 <= w_readData2;
            r_exImm       <= w_imm;
            r_exRd        <= w_rd;
            r_exRn        <= w_rn;
            r_exRm2       <= w_rm2;
            r_exRegWrite  <= w_regWrite;
            r_exMemRead   <= w_memRead;
            r_exMemWrite  <= w_memWrite;
            r_exALUSrc    <= w_aluSrc;
            r_exSetFlags  <= w_setFlags;
            r_exBranch    <= w_branch;
            r_exCBZ       <= w_cbz;
            r_exBLT       <= w_blt;
            r_exALUOp     <= w_aluOp;
        end
    end

    assign exValid     = r_exValid;
    assign exPC        = r_exPC;
    assign exReadData1 = r_exReadData1;
    assign exReadData2 = r_exReadData2;
    assign exImm       = r_exImm;
    assign exRd        = r_exRd;
    assign exRn        = r_exRn;
    assign exRm2       = r_exRm2;
    assign exRegWrite  = r_exRegWrite;
    assign exMemRead   = r_exMemRead;
    assign exMemWrite  = r_exMemWrite;
    assign exALUSrc    = r_exALUSrc;
    assign exSetFlags  = r_exSetFlags;
    assign exBranch    = r_exBranch;
    assign exCBZ       = r_exCBZ;
    assign exBLT       = r_exBLT;
    assign exALUOp     = r_exALUOp;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_decode_stage
// Brief   : Scoreboard bench for the LEGv8 decode stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instruction_decode_stage;

    localparam logic [7:0] c_RW = 8'h80, c_MR = 8'h40, c_MW = 8'h20, c_AS = 8'h10;
    localparam logic [7:0] c_SF = 8'h08, c_BR = 8'h04, c_CB = 8'h02, c_BL = 8'h01;
    localparam logic [2:0] c_PASS = 3'b000, c_ADD = 3'b010, c_SUB = 3'b011, c_AND = 3'b100;
    localparam logic [63:0] c_M8 = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] c_M4 = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [7:0]  ctl;
        logic [2:0]  alu;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm2;
        logic [63:0] d1;
        logic [63:0] d2;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instructionStageIn;
    logic [63:0] pcStageIn;
    logic        flush, wbRegWrite;
    logic [4:0]  wbRd;
    logic [63:0] wbData;
    logic        stall, exValid;
    logic [63:0] exPC, exReadData1, exReadData2, exImm;
    logic [4:0]  exRd, exRn, exRm2;
    logic        exRegWrite, exMemRead, exMemWrite, exALUSrc;
    logic        exSetFlags, exBranch, exCBZ, exBLT;
    logic [2:0]  exALUOp;

    int   totalCount = 0;
    int   badCount   = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    instruction_decode_stage #(.DATA_WIDTH(64), .ZERO_REG(5'd31)) dut (
        .clk(clk), .reset(reset), .instructionStageIn(instructionStageIn),
        .pcStageIn(pcStageIn), .flush(flush), .wbRegWrite(wbRegWrite),
        .wbRd(wbRd), .wbData(wbData), .stall(stall), .exValid(exValid),
        .exPC(exPC), .exReadData1(exReadData1), .exReadData2(exReadData2),
        .exImm(exImm), .exRd(exRd), .exRn(exRn), .exRm2(exRm2),
        .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exALUSrc(exALUSrc), .exSetFlags(exSetFlags), .exBranch(exBranch),
        .exCBZ(exCBZ), .exBLT(exBLT), .exALUOp(exALUOp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCount++;
        if (obs !== exp) begin
            badCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [63:0] pc, input logic [7:0] ctl,
                                input logic [2:0] alu, input logic [63:0] imm,
                                input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm2,
                                input logic [63:0] d1, input logic [63:0] d2);
        exp_t e;
        e.valid = v; e.pc = pc; e.ctl = ctl; e.alu = alu; e.imm = imm;
        e.rd = rd; e.rn = rn; e.rm2 = rm2; e.d1 = d1; e.d2 = d2;
        return e;
    endfunction

    function automatic exp_t rstv();
        return mk(1'b0, 64'd0, 8'h00, c_PASS, 64'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0);
    endfunction

    function automatic exp_t bub();
        return mk(1'b0, 64'd0, 8'h00, c_PASS, 64'd0, 5'd31, 5'd0, 5'd0, 64'd0, 64'd0);
    endfunction

    task automatic compareEx(input string tag, input exp_t e);
        check({tag, ".valid"}, {63'd0, exValid}, {63'd0, e.valid});
        check({tag, ".pc"}, exPC, e.pc);
        check({tag, ".ctl"}, {56'd0, exRegWrite, exMemRead, exMemWrite, exALUSrc,
                              exSetFlags, exBranch, exCBZ, exBLT}, {56'd0, e.ctl});
        check({tag, ".alu"}, {61'd0, exALUOp}, {61'd0, e.alu});
        check({tag, ".imm"}, exImm, e.imm);
        check({tag, ".rd"}, {59'd0, exRd}, {59'd0, e.rd});
        check({tag, ".rn"}, {59'd0, exRn}, {59'd0, e.rn});
        check({tag, ".rm2"}, {59'd0, exRm2}, {59'd0, e.rm2});
        check({tag, ".rd1"}, exReadData1, e.d1);
        check({tag, ".rd2"}, exReadData2, e.d2);
    endtask

    // Drive one ID cycle, check stall before the edge, score ID/EX after it.
    task automatic step(input string tag, input logic [31:0] ins, input logic [63:0] pc,
                        input logic fl, input logic rs, input logic wbw, input logic [4:0] wbr,
                        input logic [63:0] wbd, input logic expStall, input exp_t e);
        exp_t got;
        @(negedge clk);
        instructionStageIn = ins; pcStageIn = pc; flush = fl; reset = rs;
        wbRegWrite = wbw; wbRd = wbr; wbData = wbd;
        #1;
        check({tag, ".stall"}, {63'd0, stall}, {63'd0, expStall});
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check({tag, ".sbq"}, 64'd0, 64'd1);
        end else begin
            got = sbq.pop_front();
            compareEx(tag, got);
        end
    endtask

    initial begin
        reset = 1'b0; instructionStageIn = '0; pcStageIn = '0; flush = 1'b0;
        wbRegWrite = 1'b0; wbRd = '0; wbData = '0;

        step("rst0", 32'h910017E1, 64'h100, 0, 0, 0, 5'd0, 64'd0, 0, rstv());
        step("rst1", 32'h910017E1, 64'h100, 0, 0, 0, 5'd0, 64'd0, 0, rstv());
        step("addi", 32'h910017E1, 64'h104, 0, 1, 0, 5'd0, 64'd0, 0,
             mk(1, 64'h104, c_RW|c_AS, c_ADD, 64'd5, 5'd1, 5'd31, 5'd31, 64'd0, 64'd0));
        step("bypass", 32'hAB020043, 64'h108, 0, 1, 1, 5'd2, 64'h1234, 0,
             mk(1, 64'h108, c_RW|c_SF, c_ADD, 64'd0, 5'd3, 5'd2, 5'd2, 64'h1234, 64'h1234));
        step("xzr", 32'hAB1F03E3, 64'h10C, 0, 1, 1, 5'd31, 64'h5555, 0,
             mk(1, 64'h10C, c_RW|c_SF, c_ADD, 64'd0, 5'd3, 5'd31, 5'd31, 64'd0, 64'd0));
        step("and", 32'h8A020048, 64'h110, 0, 1, 0, 5'd0, 64'd0, 0,
             mk(1, 64'h110, c_RW, c_AND, 64'd0, 5'd8, 5'd2, 5'd2, 64'h1234, 64'h1234));
        step("ldur", 32'hF85F80A4, 64'h114, 0, 1, 1, 5'd5, 64'h100, 0,
             mk(1, 64'h114, c_RW|c_MR|c_AS, c_ADD, c_M8, 5'd4, 5'd5, 5'd31, 64'h100, 64'd0));
        step("luStall", 32'hAB070086, 64'h118, 0, 1, 0, 5'd0, 64'd0, 1, bub());
        step("luIssue", 32'hAB070086, 64'h118, 0, 1, 1, 5'd7, 64'h77, 0,
             mk(1, 64'h118, c_RW|c_SF, c_ADD, 64'd0, 5'd6, 5'd4, 5'd7, 64'd0, 64'h77));
        step("ldurXzr", 32'hF84000BF, 64'h11C, 0, 1, 0, 5'd0, 64'd0, 0,
             mk(1, 64'h11C, c_RW|c_MR|c_AS, c_ADD, 64'd0, 5'd31, 5'd5, 5'd31, 64'h100, 64'd0));
        step("xzrUse", 32'hAB1F03E6, 64'h120, 0, 1, 0, 5'd0, 64'd0, 0,
             mk(1, 64'h120, c_RW|c_SF, c_ADD, 64'd0, 5'd6, 5'd31, 5'd31, 64'd0, 64'd0));
        step("ldur2", 32'hF85F80A4, 64'h124, 0, 1, 0, 5'd0, 64'd0, 0,
             mk(1, 64'h124, c_RW|c_MR|c_AS, c_ADD, c_M8, 5'd4, 5'd5, 5'd31, 64'h100, 64'd0));
        step("flush", 32'hAB070086, 64'h128, 1, 1, 0, 5'd0, 64'd0, 0, bub());
        step("b", 32'h17FFFFFF, 64'h12C, 0, 1, 0, 5'd0, 64'd0, 0,
             mk(1, 64'h12C, c_BR, c_PASS, c_M4, 5'd31, 5'd31, 5'd31, 64'd0, 64'd0));
        step("cbz", 32'hB4000069, 64'h130, 0, 1, 1, 5'd9, 64'h99, 0,
             mk(1, 64'h130, c_CB, c_PASS, 64'd12, 5'd9, 5'd3, 5'd9, 64'd0, 64'h99));
        step("blt", 32'h54FFFFCB, 64'h134, 0, 1, 0, 5'd0, 64'd0, 0,
             mk(1, 64'h134, c_BL, c_PASS, c_M8, 5'd11, 5'd30, 5'd31, 64'd0, 64'd0));
        step("stur", 32'hF80100A2, 64'h138, 0, 1, 0, 5'd0, 64'd0, 0,
             mk(1, 64'h138, c_MW|c_AS, c_ADD, 64'd16, 5'd2, 5'd5, 5'd2, 64'h100, 64'h1234));
        step("subs", 32'hEB05004A, 64'h13C, 0, 1, 0, 5'd0, 64'd0, 0,
             mk(1, 64'h13C, c_RW|c_SF, c_SUB, 64'd0, 5'd10, 5'd2, 5'd5, 64'h1234, 64'h100));
        step("undef", 32'h00000000, 64'h140, 0, 1, 0, 5'd0, 64'd0, 0, bub());
        step("ldur3", 32'hF85F80A4, 64'h144, 0, 1, 0, 5'd0, 64'd0, 0,
             mk(1, 64'h144, c_RW|c_MR|c_AS, c_ADD, c_M8, 5'd4, 5'd5, 5'd31, 64'h100, 64'd0));
        step("rstStall", 32'hAB070086, 64'h148, 0, 0, 0, 5'd0, 64'd0, 0, rstv());
        step("postRst", 32'h8A020048, 64'h14C, 0, 1, 0, 5'd0, 64'd0, 0,
             mk(1, 64'h14C, c_RW, c_AND, 64'd0, 5'd8, 5'd2, 5'd2, 64'd0, 64'd0));

        check("sbqDrained", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_decode_stage.md
Name: instruction_decode_stage

Overview:
- Pipeline decode stage sitting directly downstream of the IF/ID register.
- Consumes the fetched instruction and PC, reads a 32x64 register file, decodes the LEGv8 subset, and generates immediates and control.
- Detects load-use hazards, stalls upstream, and inserts bubbles.
- Captures all results in the ID/EX pipeline register feeding execute.

Parameters:
- DATA_WIDTH, 64, register/PC/immediate width (only 64 supported).
- ZERO_REG, 31, register index hard-wired to zero (XZR).

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low (0 = reset, sampled on rising clk).
- instructionStageIn  input  32  instruction from IF/ID.
- pcStageIn  input  64  PC of that instruction from IF/ID.
- flush  input  1  branch taken downstream; squash the instruction in ID.
- wbRegWrite  input  1  write-back enable.
- wbRd  input  5  write-back destination index.
- wbData  input  64  write-back data.
- stall  output  1  combinational; 1 = IF/ID and PC must hold.
- exValid  output  1  ID/EX holds a real instruction (0 = bubble).
- exPC  output  64  registered PC.
- exReadData1, exReadData2  output  64  registered operand values.
- exImm  output  64  registered extended immediate.
- exRd, exRn, exRm2  output  5 each  destination, source 1, and source 2 indices (for forwarding).
- exRegWrite, exMemRead, exMemWrite, exALUSrc, exSetFlags, exBranch, exCBZ, exBLT  output  1 each  registered control.
- exALUOp  output  3  000 = pass B, 010 = add, 011 = subtract, 100 = and.

Behaviour:
- Latency: one cycle. Fields decoded in cycle N appear on ex* outputs after the rising edge ending cycle N.
- Reset (reset=0 at a rising edge):
  - All ex* outputs go to 0, and all 32 registers are cleared.
  - stall is forced to 0 while reset=0.
  - Reset mid-stall drops the stalled instruction.
- Decode, by opcode bits [31:21]:
  - ADDI (10 bits 1001000100): RegWrite, ALUSrc, ALUOp=add, imm = zero-extended [21:10].
  - ADDS (10101011000): RegWrite, SetFlags, ALUOp=add.
  - SUBS (11101011000): RegWrite, SetFlags, ALUOp=subtract.
  - AND (10001010000): RegWrite, ALUOp=and.
  - LDUR (11111000010): RegWrite, MemRead, ALUSrc, ALUOp=add, imm = sign-extended [20:12].
  - STUR (11111000000): MemWrite, ALUSrc, ALUOp=add, imm = sign-extended [20:12].
  - B (6 bits 000101): Branch, imm = sign-extended [25:0] shifted left 2.
  - CBZ (8 bits 10110100): CBZ, ALUOp=pass B, imm = sign-extended [23:5] shifted left 2.
  - B.LT (8 bits 01010100 with [4:0] = 01011): BLT, same imm as CBZ.
  - Any other encoding: bubble (all control 0, exValid=0).
- Register indices:
  - Rn = [9:5], Rd = [4:0].
  - Second source = [20:16] for R-type; = [4:0] (Rt) for STUR and CBZ; = ZERO_REG otherwise.
  - exRm2 carries the second-source index actually read.
- Register file:
  - Write on rising edge when wbRegWrite=1 and wbRd != ZERO_REG.
  - Reading ZERO_REG returns 0 regardless of writes.
  - Same-cycle write/read of the same index returns wbData (write-through bypass).
- Load-use hazard: stall=1 when all of the following hold:
  - exMemRead=1, exValid=1, exRd != ZERO_REG;
  - exRd equals Rn, or exRd equals a second source the current instruction actually uses (R-type, STUR, CBZ);
  - flush=0.
  - While stall=1: ID/EX loads a bubble and the instruction in ID is re-presented next cycle.
  - One stall cycle per hazard suffices.
- Flush has priority over stall: stall is forced 0, and ID/EX loads a bubble.
- Bubble definition: exValid=0, all control bits 0, exRd=ZERO_REG; data fields don't-care (implementation zeroes them).

Test Plan:
- Reset held 2 cycles, then ADDI X1,X31,#5 (0x910017E1) -> next cycle: exValid=1, exRegWrite=1, exALUSrc=1, exImm=5, exRd=1, exReadData1=0.
- wbRegWrite=1, wbRd=2, wbData=0x1234 in the same cycle as ADDS X3,X2,X2 -> exReadData1 = exReadData2 = 0x1234 (bypass); repeat with wbRd=31 -> reads 0.
- LDUR X4,[X5,#-8] followed by ADDS X6,X4,X7 -> LDUR shows exImm=0xFFFFFFFFFFFFFFF8 and exMemRead=1; stall=1 for exactly one cycle; bubble (exValid=0); ADDS then issues.
- LDUR to X31 followed by a consumer of X31 -> stall stays 0.
- Load-use hazard with flush=1 in the same cycle -> stall=0, bubble loaded.
- B with imm26 = -1 -> exImm = 0xFFFFFFFFFFFFFFFC, exBranch=1.
- CBZ X9, imm19=3 -> exImm=12, exCBZ=1, exRm2=9.
- Undefined opcode 0x00000000 -> exValid=0, all control bits 0.
- reset=0 asserted during a stall -> all ex* outputs 0 and stall=0 at the next edge; registers read 0 afterwards.
